marine_radar_pulse_sequencer: RTL



---
 rtl/marine_radar_pkg.sv | 27 ++
 rtl/marine_radar_pulse_sequencer_if.sv | 33 +++
 rtl/mr_edge_detect.sv | 19 +
 rtl/marine_radar_pulse_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/marine_radar_pkg.sv
// Shared definitions for the marine radar write-side record path.
// Holds the sequencer state encoding, record framing constants and a
// helper that tests whether a word count sits on a USB packet boundary.
package marine_radar_pkg;

   localparam int unsigned HEADER_LEN    = 4;
   localparam int unsigned PKT_WORDS_DEF = 256;
   localparam logic [15:0] MAGIC_DEF     = 16'hA5A5;
   localparam int unsigned SAMPLE_W      = 16;
   localparam int unsigned USEDW_W       = 12;
   localparam int unsigned WCNT_W        = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DELAY,
      ST_SAMPLES,
      ST_PAD
   } state_t;

   // True when a record of 'words' words ends exactly on a packet boundary.
   function automatic logic pkt_aligned(input logic [WCNT_W-1:0] words,
                                        input int unsigned pkt);
      return ((32'(words) % pkt) == 32'd0);
   endfunction

endpackage

// File: rtl/marine_radar_pulse_sequencer_if.sv
// Sample/FIFO bus between the digitizer, the sequencer and marine_radar_buffer.
//   sample_strobe/sample_in : digitizer word valid / data
//   fifo_wrusedw/fifo_full  : buffer write-side fill status
//   rxstrobe_out/data_out   : write strobe / data into the buffer
// master = sequencer side, slave = digitizer/buffer side.
interface marine_radar_pulse_sequencer_if;
   import marine_radar_pkg::*;

   logic                sample_strobe;
   logic [SAMPLE_W-1:0] sample_in;
   logic [USEDW_W-1:0]  fifo_wrusedw;
   logic                fifo_full;
   logic                rxstrobe_out;
   logic [SAMPLE_W-1:0] data_out;

   modport master (
      input  sample_strobe,
      input  sample_in,
      input  fifo_wrusedw,
      input  fifo_full,
      output rxstrobe_out,
      output data_out
   );

   modport slave (
      output sample_strobe,
      output sample_in,
      output fifo_wrusedw,
      output fifo_full,
      input  rxstrobe_out,
      input  data_out
   );
endinterface

// File: rtl/mr_edge_detect.sv
// 1-bit rising-edge detector: registers the previous input value.
//   rxclk, reset : clock, synchronous active-high reset
//   din          : synchronised input
//   rise_c       : combinational pulse, din high now and low last cycle
module mr_edge_detect (
   input  logic rxclk,
   input  logic reset,
   input  logic din,
   output logic rise_c
);
   logic din_q;

   always_ff @(posedge rxclk) begin
      if (reset) din_q <= 1'b0;
      else       din_q <= din;
   end

   assign rise_c = din & ~din_q;
endmodule

// File: rtl/marine_radar_pulse_sequencer.sv
// Write-side record framer in front of marine_radar_buffer.
// Each accepted radar trigger produces one record: 4 header words, n_samples
// digitizer words after a strobe-counted delay, then zero padding up to a
// whole number of PKT_WORDS-word USB packets. A trigger is only accepted
// when the FIFO can hold the entire padded record.
//   rxclk, reset       : clock, synchronous active-high reset
//   enable             : accept new triggers while high
//   trig, acp, arp     : synchronised trigger / azimuth count / heading pulses
//   n_samples          : samples per pulse (latched at accept)
//   trig_delay         : strobes skipped before capture (latched at accept)
//   bus                : sample input, FIFO status and buffer write port
//   busy               : record in progress
//   pulse_count        : trigger edges seen (wraps)
//   pulses_dropped     : rejected triggers (saturates)
module marine_radar_pulse_sequencer
   import marine_radar_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4095,
   parameter int unsigned PKT_WORDS  = PKT_WORDS_DEF,
   parameter logic [15:0] MAGIC      = MAGIC_DEF
) (
   input  logic                           rxclk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           trig,
   input  logic                           acp,
   input  logic                           arp,
   input  logic [10:0]                    n_samples,
   input  logic [15:0]                    trig_delay,
   marine_radar_pulse_sequencer_if.master bus,
   output logic                           busy,
   output logic [15:0]                    pulse_count,
   output logic [15:0]                    pulses_dropped
);

   logic trig_rise_c, acp_rise_c, arp_rise_c;

   mr_edge_detect u_trig_edge (.rxclk(rxclk), .reset(reset), .din(trig), .rise_c(trig_rise_c));
   mr_edge_detect u_acp_edge  (.rxclk(rxclk), .reset(reset), .din(acp),  .rise_c(acp_rise_c));
   mr_edge_detect u_arp_edge  (.rxclk(rxclk), .reset(reset), .din(arp),  .rise_c(arp_rise_c));

   state_t              state_q, state_n;
   logic [1:0]          hidx_q, hidx_n;
   logic [15:0]         dcnt_q, dcnt_n;
   logic [10:0]         scnt_q, scnt_n;
   logic [10:0]         nlat_q, nlat_n;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_n, wcnt_inc_c;
   logic [15:0]         pnum_q, pnum_n;
   logic [15:0]         azl_q, azl_n;
   logic [15:0]         az_q;
   logic [15:0]         pulse_count_q, dropped_q;
   logic                stb_q, stb_n;
   logic [15:0]         data_q, data_n;
   logic                busy_q, busy_n;

   // Admission: padded record length must fit in the free FIFO space.
   logic [31:0] rec_len_c, req_words_c, used_c;
   logic        room_ok_c, accept_c, drop_c;

   assign rec_len_c   = 32'(n_samples) + HEADER_LEN;
   assign req_words_c = ((rec_len_c + PKT_WORDS - 32'd1) / PKT_WORDS) * PKT_WORDS;
   assign used_c      = 32'(bus.fifo_wrusedw);
   assign room_ok_c   = (used_c <= FIFO_DEPTH) && ((FIFO_DEPTH - used_c) >= req_words_c);
   assign accept_c    = trig_rise_c && (state_q == ST_IDLE) && enable
                        && !bus.fifo_full && room_ok_c;
   assign drop_c      = trig_rise_c && !accept_c;
   assign wcnt_inc_c  = wcnt_q + WCNT_W'(1);

   // Next-state and next-output logic; output words are registered, so the
   // accept cycle already launches the MAGIC word.
   always_comb begin
      state_n = state_q;
      hidx_n  = hidx_q;
      dcnt_n  = dcnt_q;
      scnt_n  = scnt_q;
      nlat_n  = nlat_q;
      wcnt_n  = wcnt_q;
      pnum_n  = pnum_q;
      azl_n   = azl_q;
      stb_n   = 1'b0;
      data_n  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_n = ST_HEADER;
               hidx_n  = 2'd1;
               dcnt_n  = trig_delay;
               scnt_n  = n_samples;
               nlat_n  = n_samples;
               pnum_n  = pulse_count_q;
               azl_n   = az_q;
               wcnt_n  = WCNT_W'(1);
               stb_n   = 1'b1;
               data_n  = MAGIC;
            end
         end
         ST_HEADER: begin
            stb_n  = 1'b1;
            wcnt_n = wcnt_inc_c;
            hidx_n = hidx_q + 2'd1;
            case (hidx_q)
               2'd1:    data_n = pnum_q;
               2'd2:    data_n = azl_q;
               default: data_n = {5'b0, nlat_q};
            endcase
            if (hidx_q == 2'(HEADER_LEN - 1)) begin
               if (dcnt_q != '0)      state_n = ST_DELAY;
               else if (scnt_q != '0) state_n = ST_SAMPLES;
               else                   state_n = ST_PAD;
            end
         end
         ST_DELAY: begin
            if (bus.sample_strobe) begin
               dcnt_n = dcnt_q - 16'd1;
               if (dcnt_q == 16'd1) state_n = (scnt_q != '0) ? ST_SAMPLES : ST_PAD;
            end
         end
         ST_SAMPLES: begin
            if (bus.sample_strobe) begin
               stb_n  = 1'b1;
               data_n = bus.sample_in;
               wcnt_n = wcnt_inc_c;
               scnt_n = scnt_q - 11'd1;
               // Skip PAD entirely when the last sample lands on a boundary.
               if (scnt_q == 11'd1)
                  state_n = pkt_aligned(wcnt_inc_c, PKT_WORDS) ? ST_IDLE : ST_PAD;
            end
         end
         ST_PAD: begin
            if (pkt_aligned(wcnt_q, PKT_WORDS)) begin
               state_n = ST_IDLE;
            end else begin
               stb_n  = 1'b1;
               wcnt_n = wcnt_inc_c;
               if (pkt_aligned(wcnt_inc_c, PKT_WORDS)) state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Busy covers the final word, which is still in the output register.
      busy_n = (state_n != ST_IDLE) || stb_n;
   end

   // Sequencer state and output registers.
   always_ff @(posedge rxclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hidx_q  <= '0;
         dcnt_q  <= '0;
         scnt_q  <= '0;
         nlat_q  <= '0;
         wcnt_q  <= '0;
         pnum_q  <= '0;
         azl_q   <= '0;
         stb_q   <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         hidx_q  <= hidx_n;
         dcnt_q  <= dcnt_n;
         scnt_q  <= scnt_n;
         nlat_q  <= nlat_n;
         wcnt_q  <= wcnt_n;
         pnum_q  <= pnum_n;
         azl_q   <= azl_n;
         stb_q   <= stb_n;
         data_q  <= data_n;
         busy_q  <= busy_n;
      end
   end

   // Trigger/drop statistics and azimuth; arp takes priority over acp.
   always_ff @(posedge rxclk) begin
      if (reset) begin
         pulse_count_q <= '0;
         dropped_q     <= '0;
         az_q          <= '0;
      end else begin
         if (trig_rise_c) pulse_count_q <= pulse_count_q + 16'd1;
         if (drop_c && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
         if (arp_rise_c)      az_q <= '0;
         else if (acp_rise_c) az_q <= az_q + 16'd1;
      end
   end

   assign bus.rxstrobe_out = stb_q;
   assign bus.data_out     = data_q;
   assign busy             = busy_q;
   assign pulse_count      = pulse_count_q;
   assign pulses_dropped   = dropped_q;

endmodule
